// File: rtl/uart_mmio_ctrl.sv
// -----------------------------------------------------------------------------
// uart_mmio_ctrl
//
// Memory-mapped UART sequencer sitting between the CPU data port / RAM read
// mux and the uart instance. It decodes a three-register window, buffers
// outgoing bytes in a TX FIFO, and issues one uart_transmit strobe per byte.
// Before it issues the next strobe, it waits for uart_is_transmitting to rise
// and then fall. Received bytes are captured on the rising edge of
// uart_received.
//
// Register window (reads are combinational from mem_addr):
//   TX_ADDR   write: push TX FIFO        read: status (no side effect)
//   RX_ADDR   read : RX data, mem_rd pops
//   STAT_ADDR read : status, mem_rd clears rx_overrun / tx_drop
//
// Status byte: [0] tx_full  [1] tx_empty  [2] rx_valid  [3] rx_overrun
//              [4] tx_busy  [5] tx_drop   [7:6] 0
//
// Ports:
//   clk                  system clock, rising edge
//   rst                  asynchronous active-low reset
//   mem_addr/wr/rd/data  CPU data-memory access
//   rd_data              read data, 0 outside the window
//   hit                  mem_addr lies inside the window
//   uart_transmit        one-cycle start strobe to the UART
//   uart_tx_byte         byte to send, held until the frame ends
//   uart_is_transmitting UART busy
//   uart_received        UART byte-valid level
//   uart_rx_byte         received byte
//
// Build option: define UART_RX_FIFO_EN to replace the single RX holding
// register with a DEPTH-entry RX FIFO.
// -----------------------------------------------------------------------------
module uart_mmio_ctrl #(
    parameter int          DEPTH     = 8,
    parameter logic [7:0]  TX_ADDR   = 8'hFF,
    parameter logic [7:0]  RX_ADDR   = 8'hFE,
    parameter logic [7:0]  STAT_ADDR = 8'hFD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] mem_addr,
    input  logic       mem_wr,
    input  logic       mem_rd,
    input  logic [7:0] mem_data,
    output logic [7:0] rd_data,
    output logic       hit,
    output logic       uart_transmit,
    output logic [7:0] uart_tx_byte,
    input  logic       uart_is_transmitting,
    input  logic       uart_received,
    input  logic [7:0] uart_rx_byte
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        BUSY
    } tx_state_t;

    tx_state_t        state;

    // TX FIFO
    logic [7:0]       tx_mem [DEPTH];
    logic [PTR_W-1:0] tx_wptr;
    logic [PTR_W-1:0] tx_rptr;
    logic [CNT_W-1:0] tx_count;
    logic             tx_full;
    logic             tx_empty;
    logic             tx_push_req;
    logic             tx_push;
    logic             tx_pop;
    logic             tx_drop;
    logic             tx_busy;

    // RX path
    logic             rx_prev;
    logic             rx_capture;
    logic             rx_pop_req;
    logic             rx_pop;
    logic             rx_valid;
    logic [7:0]       rx_head;
    logic             rx_ovr_set;
    logic             rx_overrun;

    logic             stat_clr;
    logic [7:0]       status;

    // -------------------------------------------------------------------------
    // Address decode
    // -------------------------------------------------------------------------
    assign hit         = (mem_addr == TX_ADDR) || (mem_addr == RX_ADDR) ||
                         (mem_addr == STAT_ADDR);
    assign tx_push_req = mem_wr && (mem_addr == TX_ADDR);
    assign rx_pop_req  = mem_rd && (mem_addr == RX_ADDR);
    assign stat_clr    = mem_rd && (mem_addr == STAT_ADDR);

    // -------------------------------------------------------------------------
    // TX FIFO
    // -------------------------------------------------------------------------
    assign tx_full  = (tx_count == FULL_CNT);
    assign tx_empty = (tx_count == '0);
    // The FSM drains the head only from IDLE.
    assign tx_pop   = (state == IDLE) && !tx_empty;
    // A pop in the same cycle frees a slot, so a push while full still lands.
    assign tx_push  = tx_push_req && (!tx_full || tx_pop);

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wptr] <= mem_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) begin
                tx_wptr <= tx_wptr + 1'b1;
            end
            if (tx_pop) begin
                tx_rptr <= tx_rptr + 1'b1;
            end
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: tx_count <= tx_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_drop <= 1'b0;
        end else if (tx_push_req && !tx_push) begin
            tx_drop <= 1'b1;
        end else if (stat_clr) begin
            tx_drop <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // TX sequencer
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            uart_transmit <= 1'b0;
            uart_tx_byte  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    uart_transmit <= 1'b0;
                    if (!tx_empty) begin
                        uart_tx_byte  <= tx_mem[tx_rptr];
                        uart_transmit <= 1'b1;
                        state         <= START;
                    end
                end
                START: begin
                    uart_transmit <= 1'b0;
                    if (uart_is_transmitting) begin
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    uart_transmit <= 1'b0;
                    if (!uart_is_transmitting) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    uart_transmit <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

    assign tx_busy = (state != IDLE);

    // -------------------------------------------------------------------------
    // RX capture
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_prev <= 1'b0;
        end else begin
            rx_prev <= uart_received;
        end
    end

    // One capture per level, however long uart_received stays high.
    assign rx_capture = uart_received && !rx_prev;

`ifdef UART_RX_FIFO_EN
    logic [7:0]       rx_mem [DEPTH];
    logic [PTR_W-1:0] rx_wptr;
    logic [PTR_W-1:0] rx_rptr;
    logic [CNT_W-1:0] rx_count;
    logic             rx_full;
    logic             rx_push;

    assign rx_full    = (rx_count == FULL_CNT);
    assign rx_valid   = (rx_count != '0);
    assign rx_head    = rx_mem[rx_rptr];
    assign rx_pop     = rx_pop_req && rx_valid;
    assign rx_push    = rx_capture && (!rx_full || rx_pop);
    assign rx_ovr_set = rx_capture && rx_full && !rx_pop;

    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wptr] <= uart_rx_byte;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_wptr  <= '0;
            rx_rptr  <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) begin
                rx_wptr <= rx_wptr + 1'b1;
            end
            if (rx_pop) begin
                rx_rptr <= rx_rptr + 1'b1;
            end
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
        end
    end
`else
    logic [7:0] rx_hold;
    logic       rx_hold_valid;

    assign rx_valid   = rx_hold_valid;
    assign rx_head    = rx_hold;
    assign rx_pop     = rx_pop_req && rx_hold_valid;
    // Overrun keeps the unread byte; a simultaneous pop makes room instead.
    assign rx_ovr_set = rx_capture && rx_hold_valid && !rx_pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_hold       <= '0;
            rx_hold_valid <= 1'b0;
        end else if (rx_capture) begin
            if (!rx_ovr_set) begin
                rx_hold       <= uart_rx_byte;
                rx_hold_valid <= 1'b1;
            end
        end else if (rx_pop) begin
            rx_hold_valid <= 1'b0;
        end
    end
`endif

    // A set in the same cycle as a status read wins over the clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_overrun <= 1'b0;
        end else if (rx_ovr_set) begin
            rx_overrun <= 1'b1;
        end else if (stat_clr) begin
            rx_overrun <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Read mux
    // -------------------------------------------------------------------------
    assign status = {2'b00, tx_drop, tx_busy, rx_overrun, rx_valid,
                     tx_empty, tx_full};

    always_comb begin
        rd_data = '0;
        if ((mem_addr == TX_ADDR) || (mem_addr == STAT_ADDR)) begin
            rd_data = status;
        end else if (mem_addr == RX_ADDR) begin
            rd_data = rx_valid ? rx_head : '0;
        end
    end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for uart_mmio_ctrl. A UART model answers each strobe with a
// FRAME-cycle busy window (hold_busy can stretch it). A monitor pops the
// expected-byte queue on every strobe.
// -----------------------------------------------------------------------------
module tb_uart_mmio_ctrl;

    localparam int          DEPTH = 8;
    localparam int          FRAME = 10;
    localparam logic [7:0]  TXA   = 8'hFF;
    localparam logic [7:0]  RXA   = 8'hFE;
    localparam logic [7:0]  STA   = 8'hFD;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] mem_addr = '0;
    logic       mem_wr = 1'b0;
    logic       mem_rd = 1'b0;
    logic [7:0] mem_data = '0;
    logic [7:0] rd_data;
    logic       hit;
    logic       uart_transmit;
    logic [7:0] uart_tx_byte;
    logic       uart_is_transmitting;
    logic       uart_received = 1'b0;
    logic [7:0] uart_rx_byte = '0;

    logic       model_busy = 1'b0;
    logic       hold_busy = 1'b0;
    assign uart_is_transmitting = model_busy | hold_busy;

    int         errors = 0;
    int         checks = 0;
    int         sent_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];

    uart_mmio_ctrl #(
        .DEPTH    (DEPTH),
        .TX_ADDR  (TXA),
        .RX_ADDR  (RXA),
        .STAT_ADDR(STA)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .mem_addr            (mem_addr),
        .mem_wr              (mem_wr),
        .mem_rd              (mem_rd),
        .mem_data            (mem_data),
        .rd_data             (rd_data),
        .hit                 (hit),
        .uart_transmit       (uart_transmit),
        .uart_tx_byte        (uart_tx_byte),
        .uart_is_transmitting(uart_is_transmitting),
        .uart_received       (uart_received),
        .uart_rx_byte        (uart_rx_byte)
    );

    always #5 clk = ~clk;

    // UART model + TX monitor
    int         busy_left = 0;
    int         cyc = 0;
    int         fall_cyc = 0;
    logic       fall_pending = 1'b0;
    logic       prev_strobe = 1'b0;
    logic       prev_busy = 1'b0;
    logic [7:0] exp_b;

    always @(negedge clk) begin
        if (!rst) begin
            busy_left    = 0;
            model_busy   = 1'b0;
            prev_strobe  = 1'b0;
            prev_busy    = 1'b0;
            fall_pending = 1'b0;
        end else begin
            cyc = cyc + 1;
            if (prev_busy && !uart_is_transmitting) begin
                fall_cyc     = cyc;
                fall_pending = 1'b1;
            end
            prev_busy = uart_is_transmitting;
            if (uart_transmit === 1'b1) begin
                checks = checks + 1;
                if (exp_q.size() == 0) begin
                    errors = errors + 1;
                    $display("FAIL tx_unexpected: strobe with byte %02h, required no strobe", uart_tx_byte);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (uart_tx_byte !== exp_b) begin
                        errors = errors + 1;
                        $display("FAIL tx_byte: got %02h, required %02h", uart_tx_byte, exp_b);
                    end
                end
                checks = checks + 1;
                if (prev_strobe) begin
                    errors = errors + 1;
                    $display("FAIL tx_consecutive: strobe high 2 cycles, required 1");
                end
                if (fall_pending) begin
                    checks = checks + 1;
                    if (cyc - fall_cyc < 1) begin
                        errors = errors + 1;
                        $display("FAIL back_to_back_gap: got %0d cycles after busy fall, required >=1", cyc - fall_cyc);
                    end
                    fall_pending = 1'b0;
                end
                sent_cnt  = sent_cnt + 1;
                busy_left = FRAME;
            end
            prev_strobe = uart_transmit;
            if (busy_left > 0) begin
                model_busy = 1'b1;
                busy_left  = busy_left - 1;
            end else begin
                model_busy = 1'b0;
            end
        end
    end

    task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        #1;
        mem_addr = a;
        mem_data = d;
        mem_wr   = 1'b1;
        @(posedge clk);
        #1;
        mem_wr = 1'b0;
    endtask

    task automatic cpu_read(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        #1;
        mem_addr = a;
        mem_rd   = 1'b1;
        #1;
        d = rd_data;
        @(posedge clk);
        #1;
        mem_rd = 1'b0;
    endtask

    task automatic peek(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        #1;
        mem_addr = a;
        #1;
        d = rd_data;
    endtask

    task automatic rx_pulse(input logic [7:0] b, input int len);
        @(negedge clk);
        #1;
        uart_rx_byte  = b;
        uart_received = 1'b1;
        repeat (len) @(negedge clk);
        #1;
        uart_received = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        peek(STA, d);
        checks = checks + 1;
        if (d !== 8'h02) begin errors = errors + 1; $display("FAIL reset_status: got %02h, required 02", d); end
        checks = checks + 1;
        if (hit !== 1'b1) begin errors = errors + 1; $display("FAIL reset_hit: got %b, required 1", hit); end
        checks = checks + 1;
        if (uart_transmit !== 1'b0 || uart_tx_byte !== 8'h00) begin
            errors = errors + 1;
            $display("FAIL reset_tx: got strobe %b byte %02h, required 0 00", uart_transmit, uart_tx_byte);
        end
        peek(8'h10, d);
        checks = checks + 1;
        if (d !== 8'h00 || hit !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL outside_window: got data %02h hit %b, required 00 0", d, hit);
        end
        peek(RXA, d);
        checks = checks + 1;
        if (d !== 8'h00) begin errors = errors + 1; $display("FAIL reset_rx_empty: got %02h, required 00", d); end
    endtask

    task automatic test_single_tx();
        logic seen;
        exp_q.push_back(8'h41);
        cpu_write(TXA, 8'h41);
        @(negedge clk); #1;
        checks = checks + 1;
        if (uart_transmit !== 1'b0) begin errors = errors + 1; $display("FAIL tx_latency_e0: got %b, required 0", uart_transmit); end
        @(negedge clk); #1;
        checks = checks + 1;
        if (uart_transmit !== 1'b1 || uart_tx_byte !== 8'h41) begin
            errors = errors + 1;
            $display("FAIL tx_latency_e1: got strobe %b byte %02h, required 1 41", uart_transmit, uart_tx_byte);
        end
        @(negedge clk); #1;
        checks = checks + 1;
        if (uart_transmit !== 1'b0 || uart_tx_byte !== 8'h41) begin
            errors = errors + 1;
            $display("FAIL tx_latency_e2: got strobe %b byte %02h, required 0 41", uart_transmit, uart_tx_byte);
        end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #1;
            if (uart_is_transmitting) seen = 1'b1;
            else if (seen) break;
        end
        checks = checks + 1;
        if (!seen || uart_is_transmitting) begin
            errors = errors + 1;
            $display("FAIL tx_frame_timeout: busy seen %b now %b, required 1 0", seen, uart_is_transmitting);
        end
        mem_addr = STA;
        #1;
        checks = checks + 1;
        if (rd_data[4] !== 1'b1) begin errors = errors + 1; $display("FAIL busy_at_fall: got %b, required 1", rd_data[4]); end
        @(negedge clk); #1;
        checks = checks + 1;
        if (rd_data !== 8'h02) begin errors = errors + 1; $display("FAIL busy_after_fall: got status %02h, required 02", rd_data); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        int pending;
        int start_sent;
        logic done;
        start_sent = sent_cnt;
        @(posedge clk); #1 hold_busy = 1'b1;
        exp_q.push_back(8'hEE);
        cpu_write(TXA, 8'hEE);
        repeat (4) @(negedge clk);
        pending = 0;
        for (int i = 0; i < 10; i++) begin
            if (pending < DEPTH) begin
                exp_q.push_back(8'(i));
                pending = pending + 1;
            end
            cpu_write(TXA, 8'(i));
        end
        peek(TXA, d);
        checks = checks + 1;
        if (d !== 8'h31) begin errors = errors + 1; $display("FAIL overflow_status: got %02h, required 31", d); end
        cpu_read(STA, d);
        checks = checks + 1;
        if (d !== 8'h31) begin errors = errors + 1; $display("FAIL overflow_stat_read: got %02h, required 31", d); end
        peek(STA, d);
        checks = checks + 1;
        if (d !== 8'h11) begin errors = errors + 1; $display("FAIL drop_cleared: got %02h, required 11", d); end
        @(posedge clk); #1 hold_busy = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 600 && !done; i++) begin
            peek(STA, d);
            if (exp_q.size() == 0 && d == 8'h02) done = 1'b1;
        end
        checks = checks + 1;
        if (!done) begin
            errors = errors + 1;
            $display("FAIL drain_timeout: %0d bytes pending status %02h, required 0 02", exp_q.size(), d);
        end
        checks = checks + 1;
        if (sent_cnt - start_sent != 9) begin
            errors = errors + 1;
            $display("FAIL sent_count: got %0d, required 9", sent_cnt - start_sent);
        end
    endtask

`ifndef UART_RX_FIFO_EN
    task automatic test_rx_overrun();
        logic [7:0] d;
        @(negedge clk); #1;
        uart_rx_byte  = 8'hA5;
        uart_received = 1'b1;
        rx_q.push_back(8'hA5);
        mem_addr = RXA;
        #1;
        checks = checks + 1;
        if (rd_data !== 8'h00) begin errors = errors + 1; $display("FAIL rx_early: got %02h, required 00", rd_data); end
        @(negedge clk); #1;
        uart_received = 1'b0;
        #1;
        checks = checks + 1;
        if (rd_data !== rx_q[0]) begin errors = errors + 1; $display("FAIL rx_latency: got %02h, required %02h", rd_data, rx_q[0]); end
        rx_pulse(8'h5A, 4);
        peek(STA, d);
        checks = checks + 1;
        if (d !== 8'h0E) begin errors = errors + 1; $display("FAIL overrun_status: got %02h, required 0E", d); end
        cpu_read(STA, d);
        peek(STA, d);
        checks = checks + 1;
        if (d !== 8'h06) begin errors = errors + 1; $display("FAIL overrun_clear: got %02h, required 06", d); end
        cpu_read(RXA, d);
        exp_b = rx_q.pop_front();
        checks = checks + 1;
        if (d !== exp_b) begin errors = errors + 1; $display("FAIL overrun_keeps_old: got %02h, required %02h", d, exp_b); end
        peek(RXA, d);
        checks = checks + 1;
        if (d !== 8'h00) begin errors = errors + 1; $display("FAIL rx_empty_after_pop: got %02h, required 00", d); end
        rx_q.push_back(8'h3C);
        rx_pulse(8'h3C, 6);
        peek(STA, d);
        checks = checks + 1;
        if (d !== 8'h06) begin errors = errors + 1; $display("FAIL rx_level_once: got status %02h, required 06", d); end
        cpu_read(RXA, d);
        exp_b = rx_q.pop_front();
        checks = checks + 1;
        if (d !== exp_b) begin errors = errors + 1; $display("FAIL rx_level_byte: got %02h, required %02h", d, exp_b); end
    endtask
`else
    task automatic test_rx_fifo();
        logic [7:0] d;
        rx_q.push_back(8'h11); rx_pulse(8'h11, 3);
        rx_q.push_back(8'h22); rx_pulse(8'h22, 1);
        rx_q.push_back(8'h33); rx_pulse(8'h33, 2);
        peek(STA, d);
        checks = checks + 1;
        if (d !== 8'h06) begin errors = errors + 1; $display("FAIL rxf_status: got %02h, required 06", d); end
        for (int i = 0; i < 3; i++) begin
            cpu_read(RXA, d);
            exp_b = rx_q.pop_front();
            checks = checks + 1;
            if (d !== exp_b) begin errors = errors + 1; $display("FAIL rxf_data%0d: got %02h, required %02h", i, d, exp_b); end
        end
        peek(STA, d);
        checks = checks + 1;
        if (d !== 8'h02) begin errors = errors + 1; $display("FAIL rxf_drained: got %02h, required 02", d); end
    endtask
`endif

    task automatic test_reset_midframe();
        logic [7:0] d;
        int start_sent;
        @(posedge clk); #1 hold_busy = 1'b1;
        exp_q.push_back(8'h77);
        cpu_write(TXA, 8'h77);
        cpu_write(TXA, 8'h78);
        cpu_write(TXA, 8'h79);
        cpu_write(TXA, 8'h7A);
        repeat (3) @(negedge clk);
        start_sent = sent_cnt;
        #2 rst = 1'b0;
        mem_addr = STA;
        #1;
        checks = checks + 1;
        if (uart_transmit !== 1'b0 || rd_data !== 8'h02) begin
            errors = errors + 1;
            $display("FAIL reset_abort: got strobe %b status %02h, required 0 02", uart_transmit, rd_data);
        end
        exp_q.delete();
        hold_busy = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        repeat (30) @(negedge clk);
        checks = checks + 1;
        if (sent_cnt != start_sent) begin
            errors = errors + 1;
            $display("FAIL reset_no_resend: got %0d strobes, required 0", sent_cnt - start_sent);
        end
        peek(STA, d);
        checks = checks + 1;
        if (d !== 8'h02) begin errors = errors + 1; $display("FAIL reset_mid_status: got %02h, required 02", d); end
    endtask

    initial begin
        test_reset();
        test_single_tx();
        test_back_to_back();
`ifndef UART_RX_FIFO_EN
        test_rx_overrun();
`else
        test_rx_fifo();
`endif
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_mmio_ctrl.md
# uart_mmio_ctrl

Memory-mapped controller that sequences the UART on behalf of the CPU. It decodes CPU data-memory accesses to a small register window, buffers outgoing bytes in a TX FIFO, and drives the UART transmit strobe one byte at a time, waiting for each frame to finish. It captures received bytes and exposes a status register. It sits between the CPU data port / RAM read mux and the `uart` instance, replacing ad-hoc strobe glue.

## Interface

Parameters:
- `DEPTH`, 8: TX FIFO entries (power of two, 2..64); also the RX FIFO depth when enabled.
- `TX_ADDR`, 8'hFF: write pushes TX FIFO; read returns status.
- `RX_ADDR`, 8'hFE: read returns RX data; read strobe pops RX.
- `STAT_ADDR`, 8'hFD: read returns status and clears sticky bits.

Ports:
- `clk` in 1: system clock; every register is clocked on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `mem_addr` in 8: CPU data address.
- `mem_wr` in 1: CPU write strobe, one cycle per write.
- `mem_rd` in 1: CPU read strobe, one cycle per read; used for pop and clear side effects.
- `mem_data` in 8: CPU write data.
- `rd_data` out 8: read data, combinational from `mem_addr`. 0 when `mem_addr` is outside the window.
- `hit` out 1: `mem_addr` is in {`TX_ADDR`, `RX_ADDR`, `STAT_ADDR`}; drives the RAM/IO read mux.
- `uart_transmit` out 1: one-cycle start strobe to the UART.
- `uart_tx_byte` out 8: byte to transmit; held stable from the strobe until the frame ends.
- `uart_is_transmitting` in 1: UART busy.
- `uart_received` in 1: UART byte-valid (level, may last more than one cycle).
- `uart_rx_byte` in 8: received byte.

## Operation

- Status byte, bit by bit:
  - [0] tx_full
  - [1] tx_empty
  - [2] rx_valid
  - [3] rx_overrun (sticky)
  - [4] tx_busy (FSM not IDLE)
  - [5] tx_drop (sticky)
  - [7:6] 0
- TX push: `mem_wr` with `mem_addr==TX_ADDR`.
  - If not full: the byte is enqueued.
  - If full: the byte is discarded and tx_drop is set.
  - If full and a pop happens in the same cycle: the push is accepted.
- TX FSM:
  - IDLE: if the FIFO is not empty, pop the head into `uart_tx_byte`, assert `uart_transmit`, and go to START.
  - START: deassert `uart_transmit`. Wait for `uart_is_transmitting=1`, then go to BUSY.
  - BUSY: wait for `uart_is_transmitting=0`, then go to IDLE.
- RX capture is on the rising edge of `uart_received` (registered previous value), so a level lasting N cycles captures exactly one byte.
- Without RX FIFO: a one-byte holding register plus rx_valid.
  - Capture while rx_valid=1 sets rx_overrun and keeps the old byte.
  - Capture and pop in the same cycle: the new byte is stored and rx_valid stays 1.
- RX pop: `mem_rd` with `mem_addr==RX_ADDR` clears rx_valid. When empty, the read returns 0 with no side effect.
- Status read: `mem_rd` at `STAT_ADDR` clears rx_overrun and tx_drop after returning them. A sticky set in the same cycle wins.
- A read at `TX_ADDR` returns status without clearing.

## Timing

- Reset values:
  - `uart_transmit`=0, `uart_tx_byte`=0.
  - FIFOs empty, FSM IDLE, all sticky bits 0.
  - Hence `rd_data` at `STAT_ADDR` reads 8'h02.
- Reset asserted mid-frame aborts immediately: FIFO contents are lost, and the strobe drops asynchronously.
- TX latency: a write sampled at edge E0 makes `uart_transmit` high from E1 to E2, with `uart_tx_byte` valid from E1.
- `uart_transmit` is never high in two consecutive cycles.
- Back-to-back bytes: the next strobe comes no earlier than 1 cycle after `uart_is_transmitting` falls (BUSY→IDLE→strobe).
- RX: a byte is readable at `RX_ADDR` one cycle after the `uart_received` rising edge is sampled.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. The count is `$clog2(DEPTH)+1` bits.

## Configuration

- `UART_RX_FIFO_EN`:
  - Defined: RX uses a DEPTH-entry FIFO. rx_valid means non-empty; rx_overrun is set only when a capture arrives while full and no pop happens that cycle.
  - Undefined: single holding register as described above.

## Test plan

- Reset: release `rst`, read `STAT_ADDR` → 8'h02. Check `uart_transmit`=0.
- Single TX: write 8'h41 to 8'hFF at E0 → `uart_transmit` high exactly E1–E2 with `uart_tx_byte`=8'h41. Model `is_transmitting` high 10 cycles → status bit4 clears one cycle after it falls.
- Overflow: DEPTH=8, hold `is_transmitting`=1, write 10 bytes 8'h00..8'h09 →
  - Status bit0=1 and bit5=1.
  - Bytes 00..07 are sent in order; 08 and 09 are never sent.
  - A status read clears bit5.
- RX overrun (macro undefined): two `uart_received` pulses (8'hA5 then 8'h5A) with no read → `RX_ADDR` reads 8'hA5 and status bit3=1. A multi-cycle `uart_received` level captures exactly once.
- RX FIFO (macro defined): 3 received bytes 8'h11, 8'h22, 8'h33 → three `RX_ADDR` reads return them in order, then status bit2=0.
- Reset mid-frame: deassert-to-assert `rst` while in BUSY with 3 bytes queued → no further `uart_transmit`, status 8'h02.
